// File: rtl/xor_parity_pkg.sv
// Shared types and helpers for the xor_parity_stream block.
package xor_parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  // Width needed to hold a beat count in the range 0..max_beats.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/xor_gate.sv
// Two-input XOR gate, the leaf cell of the reduction trees.
module xor_gate (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_reduce.sv
// WIDTH-bit XOR reduction built as a balanced binary tree of xor_gate cells.
// Depth is ceil(log2(WIDTH)); a 1-bit input passes straight through.
module xor_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  generate
    if (WIDTH == 1) begin : g_leaf
      assign parity = data[0];
    end else begin : g_node
      // Lower half takes the extra bit so both subtrees stay balanced.
      localparam int LO_W = (WIDTH + 1) / 2;
      localparam int HI_W = WIDTH - LO_W;

      logic lo_par;
      logic hi_par;

      xor_reduce #(.WIDTH(LO_W)) u_lo (
        .data   (data[LO_W-1:0]),
        .parity (lo_par)
      );

      xor_reduce #(.WIDTH(HI_W)) u_hi (
        .data   (data[WIDTH-1:LO_W]),
        .parity (hi_par)
      );

      xor_gate u_xor (
        .a (lo_par),
        .b (hi_par),
        .y (parity)
      );
    end
  endgenerate

endmodule

// File: rtl/xor_parity_stream.sv
// Streaming frame parity engine: XOR-reduces each accepted beat, accumulates
// across a frame terminated by in_last, then presents parity, saturating beat
// count and overflow flag until the downstream handshake.
// Optional checker mode: define XOR_PARITY_STREAM_CHECK_EN to add in_pchk /
// out_err, comparing the computed frame parity against a received check bit.
module xor_parity_stream
  import xor_parity_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ODD       = 0,
  parameter int MAX_BEATS = 16,
  localparam int CW       = cnt_width(MAX_BEATS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic [CW-1:0]    out_beats,
`ifdef XOR_PARITY_STREAM_CHECK_EN
  input  logic             in_pchk,
  output logic             out_err,
`endif
  output logic             out_overflow
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BEATS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic          ODD_BIT = (ODD != 0);

  state_t          state;
  state_t          state_nxt;
  logic            acc;
  logic            acc_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            ovf;
  logic            ovf_nxt;
  logic            beat_par;
  logic            accept;
  logic            take_last;

  xor_reduce #(.WIDTH(WIDTH)) u_reduce (
    .data   (in_data),
    .parity (beat_par)
  );

  // Ready depends on state only, so there is no combinational path from out_ready.
  assign in_ready  = (state != HOLD);
  assign accept    = in_valid && in_ready;
  assign take_last = accept && in_last;

  // Next-state and next accumulator values for the current beat.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = beat_par;
          cnt_nxt   = CNT_ONE;
          ovf_nxt   = 1'b0;
          state_nxt = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_nxt = acc ^ beat_par;
          cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
          ovf_nxt = ovf | (cnt == CNT_MAX);
          if (in_last) begin
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Running frame accumulator, beat counter and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= 1'b0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      acc <= acc_nxt;
      cnt <= cnt_nxt;
      ovf <= ovf_nxt;
    end
  end

  // Result registers: captured from the final beat's values, held until handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_parity   <= 1'b0;
      out_beats    <= '0;
      out_overflow <= 1'b0;
`ifdef XOR_PARITY_STREAM_CHECK_EN
      out_err      <= 1'b0;
`endif
    end else if (take_last) begin
      out_valid    <= 1'b1;
      out_parity   <= acc_nxt ^ ODD_BIT;
      out_beats    <= cnt_nxt;
      out_overflow <= ovf_nxt;
`ifdef XOR_PARITY_STREAM_CHECK_EN
      out_err      <= (acc_nxt ^ ODD_BIT) != in_pchk;
`endif
    end else if ((state == HOLD) && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule
